// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if
//   Handshake and data bundle between the ID/EX register (master side) and
//   the multicycle ALU (slave side).
//   Request : in_valid, in_ready, op[4:0], a, b, shamt
//   Response: out_valid, out_ready, result, result_hi, zero, div_by_zero
//   The master drives the request and out_ready. The slave drives in_ready
//   and the response.
interface multicycle_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_hi;
  logic               zero;
  logic               div_by_zero;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, result_hi, zero, div_by_zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Clocked ALU. Most opcodes complete in one cycle. MULT is an iterative
//   unsigned shift-add multiply and DIV is an iterative unsigned restoring
//   divide. Each iterative op takes WIDTH cycles and returns a double-width
//   result.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of multicycle_alu_if. It carries the input handshake
//            (in_valid/in_ready, op, a, b, shamt) and the output handshake
//            (out_valid/out_ready, result, result_hi, zero, div_by_zero).
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_XOR  = 5'd0;
  localparam logic [4:0] OP_SLL  = 5'd1;
  localparam logic [4:0] OP_SRL  = 5'd2;
  localparam logic [4:0] OP_SRA  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_MULT = 5'd6;
  localparam logic [4:0] OP_DIV  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_NOR  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_SLT  = 5'd11;
  localparam logic [4:0] OP_BEQ  = 5'd13;
  localparam logic [4:0] OP_BNE  = 5'd14;
  localparam logic [4:0] OP_BLEZ = 5'd15;
  localparam logic [4:0] OP_BGTZ = 5'd16;
  localparam logic [4:0] OP_BGEZ = 5'd17;
  localparam logic [4:0] OP_LUI  = 5'd18;
  localparam logic [4:0] OP_SLTU = 5'd19;
  localparam logic [4:0] OP_SLLV = 5'd25;
  localparam logic [4:0] OP_SRLV = 5'd26;
  localparam logic [4:0] OP_SRAV = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Shared work register: {partial product, multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV.
  logic [2*WIDTH-1:0] wk_q, wk_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;

  logic               accept_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic [2*WIDTH-1:0] mul_step_s;
  logic [2*WIDTH-1:0] div_step_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic signed [WIDTH-1:0] a_sgn_s;
  logic signed [WIDTH-1:0] b_sgn_s;

  // Widens a condition bit into a 0/1 result word.
  function automatic logic [WIDTH-1:0] flag_word(input logic cond);
    return {{(WIDTH-1){1'b0}}, cond};
  endfunction

  assign bus.in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept_s        = bus.in_valid & bus.in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

  // Single-cycle ALU result decoded from the live input operands.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    a_sgn_s   = $signed(bus.a);
    b_sgn_s   = $signed(bus.b);
    case (bus.op)
      OP_XOR:  alu_res_s = bus.a ^ bus.b;
      OP_SLL:  alu_res_s = bus.b << bus.shamt;
      OP_SRL:  alu_res_s = bus.b >> bus.shamt;
      OP_SRA:  alu_res_s = b_sgn_s >>> bus.shamt;
      OP_ADD:  alu_res_s = bus.a + bus.b;
      OP_SUB:  alu_res_s = bus.a - bus.b;
      OP_OR:   alu_res_s = bus.a | bus.b;
      OP_NOR:  alu_res_s = ~(bus.a | bus.b);
      OP_AND:  alu_res_s = bus.a & bus.b;
      OP_SLT:  alu_res_s = flag_word(a_sgn_s < b_sgn_s);
      OP_SLTU: alu_res_s = flag_word(bus.a < bus.b);
      OP_BEQ:  alu_res_s = flag_word(bus.a == bus.b);
      OP_BNE:  alu_res_s = flag_word(bus.a != bus.b);
      // Branch-on-sign compares treat a as signed against zero.
      OP_BLEZ: alu_res_s = flag_word(bus.a[WIDTH-1] | (bus.a == {WIDTH{1'b0}}));
      OP_BGTZ: alu_res_s = flag_word(~bus.a[WIDTH-1] & (bus.a != {WIDTH{1'b0}}));
      OP_BGEZ: alu_res_s = flag_word(~bus.a[WIDTH-1]);
      OP_LUI:  alu_res_s = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLLV: alu_res_s = bus.b << bus.a[SHAMT_W-1:0];
      OP_SRLV: alu_res_s = bus.b >> bus.a[SHAMT_W-1:0];
      OP_SRAV: alu_res_s = b_sgn_s >>> bus.a[SHAMT_W-1:0];
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration step each for multiply and divide, taken from the work register.
  always_comb begin
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole register right with the carry.
    mul_sum_s  = {1'b0, wk_q[2*WIDTH-1:WIDTH]} +
                 {1'b0, (wk_q[0] ? opb_q : {WIDTH{1'b0}})};
    mul_step_s = {mul_sum_s, wk_q[WIDTH-1:1]};
    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the difference only when it does not go negative.
    div_shift_s = wk_q[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_shift_s - {1'b0, opb_q};
    if (div_diff_s[WIDTH]) begin
      div_step_s = {div_shift_s[WIDTH-1:0], wk_q[WIDTH-2:0], 1'b0};
    end else begin
      div_step_s = {div_diff_s[WIDTH-1:0], wk_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state and result-register logic for the control FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wk_d        = wk_q;
    opb_d       = opb_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    dbz_d       = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (bus.op == OP_MULT) begin
            state_d     = ST_MUL;
            wk_d        = {{WIDTH{1'b0}}, bus.a};
            opb_d       = bus.b;
            cnt_d       = CNT_W'(WIDTH);
            out_valid_d = 1'b0;
          end else if ((bus.op == OP_DIV) && (bus.b != {WIDTH{1'b0}})) begin
            state_d     = ST_DIV;
            wk_d        = {{WIDTH{1'b0}}, bus.a};
            opb_d       = bus.b;
            cnt_d       = CNT_W'(WIDTH);
            out_valid_d = 1'b0;
          end else if (bus.op == OP_DIV) begin
            // Divide by zero finishes immediately with a flagged result.
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = {WIDTH{1'b1}};
            result_hi_d = bus.a;
            dbz_d       = 1'b1;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res_s;
            result_hi_d = {WIDTH{1'b0}};
            dbz_d       = 1'b0;
          end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_MUL: begin
        wk_d  = mul_step_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = mul_step_s[WIDTH-1:0];
          result_hi_d = mul_step_s[2*WIDTH-1:WIDTH];
          dbz_d       = 1'b0;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        wk_d  = div_step_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = div_step_s[WIDTH-1:0];
          result_hi_d = div_step_s[2*WIDTH-1:WIDTH];
          dbz_d       = 1'b0;
        end else begin
          state_d = ST_DIV;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    zero_d = (result_d == {WIDTH{1'b0}});
  end

  // State, iteration and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      wk_q        <= {(2*WIDTH){1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      zero_q      <= 1'b1;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wk_q        <= wk_d;
      opb_q       <= opb_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu
//   Scoreboard bench for multicycle_alu. The stimulus process pushes each
//   expected response at issue time. A separate monitor pops and compares
//   whenever a result is consumed.
module tb_multicycle_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_alu_if #(.WIDTH(W)) bus ();
  multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: a result visible with out_ready high is consumed at the next edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%08h, expected no result", bus.result);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.result, e.res);
        check("result_hi", bus.result_hi, e.hi);
        check("zero", {31'd0, bus.zero}, {31'd0, e.z});
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
      end
    end
  end

  // Present one op, wait (bounded) for acceptance, and queue its expectation.
  // Called and returns 1 time unit after a rising edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] sh, input logic [31:0] er, input logic [31:0] eh,
                       input logic ed, input bit push, output int waited);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = aa;
    bus.b = bb;
    bus.shamt = sh;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", waited);
    end else if (push) begin
      e.res = er;
      e.hi = eh;
      e.z = (er == 32'd0);
      e.dz = ed;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Single-cycle op with out_ready high: result must be visible right after the accept edge.
  task automatic single(input string name, input logic [4:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [4:0] sh, input logic [31:0] er);
    int w;
    issue(o, aa, bb, sh, er, 32'd0, 1'b0, 1'b1, w);
    check({name, "_latency"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int cyc;
    bit ok;
    bus.in_valid = 1'b0;
    bus.op = 5'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.shamt = 5'd0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_result_hi", bus.result_hi, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // ADD wrap to zero
    single("add_wrap", 5'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);

    // MULT with latency and in_ready checks
    issue(5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1, w);
    cyc = 0;
    ok = !bus.in_ready && !bus.out_valid;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!bus.out_valid && bus.in_ready) ok = 1'b0;
    end
    check("mult_latency", cyc, 32'd32);
    check("mult_in_ready_low", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;

    // DIV 100 / 7
    issue(5'd7, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, 1'b1, w);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("div_latency", cyc, 32'd32);
    @(posedge clk);
    #1;

    // DIV by zero finishes immediately
    issue(5'd7, 32'd5, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, w);
    check("div0_latency", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Streaming shifts/compare/LUI: accepted back to back, no waits
    issue(5'd3, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'd0, 1'b0, 1'b1, w);
    issue(5'd27, 32'h0000_0024, 32'h8000_0000, 5'd0, 32'hF800_0000, 32'd0, 1'b0, 1'b1, w);
    check("stream_wait_srav", w, 32'd0);
    issue(5'd19, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'd0, 1'b0, 1'b1, w);
    check("stream_wait_sltu", w, 32'd0);
    issue(5'd18, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 32'd0, 1'b0, 1'b1, w);
    check("stream_wait_lui", w, 32'd0);

    // Other single-cycle opcodes, including one unassigned encoding
    single("xor", 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0);
    single("sll", 5'd1, 32'd0, 32'd1, 5'd31, 32'h8000_0000);
    single("srl", 5'd2, 32'd0, 32'h8000_0000, 5'd31, 32'd1);
    single("sub", 5'd5, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF);
    single("or", 5'd8, 32'h00FF_0000, 32'h0000_FF00, 5'd0, 32'h00FF_FF00);
    single("nor", 5'd9, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    single("and", 5'd10, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd0, 32'h3030_3030);
    single("slt", 5'd11, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    single("sltu", 5'd19, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
    single("beq", 5'd13, 32'd5, 32'd5, 5'd0, 32'd1);
    single("bne", 5'd14, 32'd5, 32'd5, 5'd0, 32'd0);
    single("blez", 5'd15, 32'h8000_0000, 32'd0, 5'd0, 32'd1);
    single("bgez", 5'd17, 32'd0, 32'd0, 5'd0, 32'd1);
    single("bgtz_neg", 5'd16, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0);
    single("sllv", 5'd25, 32'hFFFF_FFE3, 32'd1, 5'd0, 32'd8);
    single("srlv", 5'd26, 32'h0000_0021, 32'h8000_0000, 5'd0, 32'h4000_0000);
    single("undef_op", 5'd12, 32'd5, 32'd5, 5'd0, 32'd0);
    @(posedge clk);
    #1;

    // Back-pressure: SUB result held with out_ready low and an op pending
    bus.out_ready = 1'b0;
    issue(5'd5, 32'd10, 32'd3, 5'd0, 32'd7, 32'd0, 1'b0, 1'b1, w);
    bus.in_valid = 1'b1;
    bus.op = 5'd10;
    bus.a = 32'h0000_000F;
    bus.b = 32'h0000_0003;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_result", bus.result, 32'd7);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(5'd10, 32'h0000_000F, 32'h0000_0003, 5'd0, 32'd3, 32'd0, 1'b0, 1'b1, w);
    check("bp_same_edge_wait", w, 32'd0);
    check("bp_new_result", bus.result, 32'd3);
    @(posedge clk);
    #1;

    // Reset 10 cycles into a MULT aborts it
    issue(5'd6, 32'd3, 32'd5, 5'd0, 32'd15, 32'd0, 1'b0, 1'b0, w);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) ok = 1'b0;
    end
    check("abort_stays_idle", {31'd0, ok}, 32'd1);
    single("bgtz_zero", 5'd16, 32'd0, 32'd0, 5'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
